// File: rtl/result_encoder_if.sv
// result_encoder_if: result-in / ASCII-byte-out handshake bundle for result_encoder
// master: result_valid, result_data, outbound_ready out; result_ready, outbound_valid, outbound_byte, busy in
// slave:  mirror of master
interface result_encoder_if #(parameter int RESULT_WIDTH = 64);
    logic                    result_valid;
    logic                    result_ready;
    logic [RESULT_WIDTH-1:0] result_data;
    logic                    outbound_valid;
    logic                    outbound_ready;
    logic [7:0]              outbound_byte;
    logic                    busy;
    modport master (
        output result_valid, result_data, outbound_ready,
        input  result_ready, outbound_valid, outbound_byte, busy
    );
    modport slave (
        input  result_valid, result_data, outbound_ready,
        output result_ready, outbound_valid, outbound_byte, busy
    );
endinterface

// File: rtl/result_encoder.sv
// result_encoder: binary result to decimal ASCII line (MSD first, leading zeros suppressed, LF-terminated)
// clk, rst_n (sync, active low); bus.slave: result_valid/result_ready/result_data in,
// outbound_valid/outbound_ready/outbound_byte out, busy high outside IDLE
module result_encoder #(
    parameter int RESULT_WIDTH = 64,
    parameter int DIGITS       = 20
) (
    input logic             clk,
    input logic             rst_n,
    result_encoder_if.slave bus
);
    localparam int CW = $clog2(RESULT_WIDTH + 1);
    localparam int IW = $clog2(DIGITS + 1);
    typedef enum logic [2:0] {IDLE, CONVERT, SCAN, SEND, TERM} state_t;
    state_t                  state;
    logic [4*DIGITS-1:0]     bcd, bcd_adj;
    logic [RESULT_WIDTH-1:0] sh;
    logic [CW-1:0]           cnt;
    logic [IW-1:0]           idx;
    logic                    started;
    logic [3:0]              nib;
    // double-dabble correction: nibbles >= 5 get +3 so the following shift carries into the next digit
    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < DIGITS; i++)
            bcd_adj[4*i +: 4] = bcd[4*i +: 4] >= 4'd5 ? bcd[4*i +: 4] + 4'd3 : bcd[4*i +: 4];
    end
    assign nib              = 4'(bcd >> {idx, 2'b00});
    assign bus.result_ready = state == IDLE;
    assign bus.busy         = state != IDLE;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state              <= IDLE;
            bcd                <= '0;
            sh                 <= '0;
            cnt                <= '0;
            idx                <= '0;
            started            <= 1'b0;
            bus.outbound_valid <= 1'b0;
            bus.outbound_byte  <= 8'h00;
        end else begin
            case (state)
                IDLE: if (bus.result_valid) begin
                    sh    <= bus.result_data;
                    bcd   <= '0;
                    cnt   <= '0;
                    idx   <= '0;
                    state <= CONVERT;
                end
                CONVERT: begin
                    {bcd, sh} <= {bcd_adj[4*DIGITS-2:0], sh, 1'b0};
                    cnt       <= cnt + 1'b1;
                    if (cnt == CW'(RESULT_WIDTH - 1)) begin
                        idx     <= IW'(DIGITS - 1);
                        started <= 1'b0;
                        state   <= SCAN;
                    end
                end
                // index 0 is never skipped, so a zero value still prints '0'
                SCAN: if (nib == 4'd0 && !started && idx != '0)
                    idx <= idx - 1'b1;
                else begin
                    bus.outbound_byte  <= {4'h3, nib};
                    bus.outbound_valid <= 1'b1;
                    started            <= 1'b1;
                    state              <= SEND;
                end
                SEND: if (bus.outbound_ready) begin
                    if (idx != '0) begin
                        idx                <= idx - 1'b1;
                        bus.outbound_valid <= 1'b0;
                        state              <= SCAN;
                    end else begin
                        bus.outbound_byte <= 8'h0A;
                        state             <= TERM;
                    end
                end
                TERM: if (bus.outbound_ready) begin
                    bus.outbound_valid <= 1'b0;
                    state              <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_result_encoder.sv
// tb_result_encoder: randomized scoreboard bench for result_encoder
module tb_result_encoder;
    localparam int RW = 64;
    localparam int DG = 20;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0, errors = 0, cyc = 0, lf_cyc = -1, mode = 0;
    logic [7:0] exp_q[$];
    int lat_q[$];
    bit first = 1'b1, prev_stall = 1'b0;
    logic [7:0] prev_byte = 8'h00;

    result_encoder_if #(.RESULT_WIDTH(RW)) bus();
    result_encoder #(.RESULT_WIDTH(RW), .DIGITS(DG)) dut(.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    initial forever @(posedge clk) cyc++;

    initial assert (10.0 ** DG > 2.0 ** RW) else begin
        $display("FAIL digits_constraint: 10^%0d does not exceed 2^%0d", DG, RW);
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // reference: decimal digits by repeated division, then LF; first byte appears after
    // RESULT_WIDTH conversion cycles, one per suppressed leading zero, plus one
    function automatic void expect_line(input logic [63:0] v, input int acc);
        logic [7:0] d[$];
        logic [63:0] x;
        x = v;
        do begin
            d.push_front(8'h30 + 8'(x % 64'd10));
            x = x / 64'd10;
        end while (x != 0);
        foreach (d[i]) exp_q.push_back(d[i]);
        exp_q.push_back(8'h0A);
        lat_q.push_back(acc + RW + (DG - d.size()) + 1);
    endfunction

    // outbound_ready driver: 0 = always ready, 1 = random, other = driven by the test
    initial forever begin
        @(posedge clk);
        #1;
        if (mode == 0) bus.outbound_ready = 1'b1;
        else if (mode == 1) bus.outbound_ready = 1'($urandom_range(0, 1));
    end

    // monitor: pops the scoreboard on every outbound transfer
    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            chk("ready_only_idle", bus.result_ready, !bus.busy);
            if (prev_stall) begin
                chk("stall_valid_held", bus.outbound_valid, 1);
                chk("stall_byte_held", bus.outbound_byte, prev_byte);
            end
            if (bus.outbound_valid && first) begin
                first = 1'b0;
                if (lat_q.size() == 0) fail("unexpected_line_start");
                else chk("first_valid_cycle", cyc, lat_q.pop_front());
            end
            if (bus.outbound_valid && bus.outbound_ready) begin
                if (exp_q.size() == 0) fail("unexpected_byte");
                else chk("outbound_byte", bus.outbound_byte, exp_q.pop_front());
                if (bus.outbound_byte == 8'h0A) begin
                    first  = 1'b1;
                    lf_cyc = cyc + 1;
                end
            end
            prev_stall = bus.outbound_valid && !bus.outbound_ready;
            prev_byte  = bus.outbound_byte;
        end
    end

    // holds result_valid until accepted; returns the accepting edge and leaves valid high
    task automatic send(input logic [63:0] v, output int acc);
        bus.result_data  = v;
        bus.result_valid = 1'b1;
        acc = -1;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            if (bus.result_ready) begin
                acc = cyc + 1;
                break;
            end
        end
        if (acc < 0) fail("accept_timeout");
        else expect_line(v, acc);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done();
        bit ok = 1'b0;
        for (int i = 0; i < 20000; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !bus.busy) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            fail("line_timeout");
            exp_q.delete();
            lat_q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic one(input logic [63:0] v);
        int a;
        send(v, a);
        bus.result_valid = 1'b0;
        wait_done();
    endtask

    task automatic wait_valid(input logic [7:0] b);
        bit ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (bus.outbound_valid && bus.outbound_byte == b) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) fail("wait_valid_timeout");
        @(posedge clk);
        #1;
    endtask

    initial begin
        int a, b;
        logic [63:0] v;
        bus.result_valid   = 1'b0;
        bus.result_data    = '0;
        bus.outbound_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_result_ready", bus.result_ready, 1);
        chk("reset_outbound_valid", bus.outbound_valid, 0);
        chk("reset_outbound_byte", bus.outbound_byte, 8'h00);
        chk("reset_busy", bus.busy, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        one(64'd0);
        one(64'd1234);
        one(64'hFFFF_FFFF_FFFF_FFFF);
        one(64'd1000);
        mode = 1;
        one(64'd507);

        mode = 0;
        send(64'd42, a);
        send(64'd7, b);
        bus.result_valid = 1'b0;
        chk("back_to_back_accept", b, lf_cyc + 1);
        wait_done();

        // abort mid-line while '8' of 9876 is stalled
        mode = 3;
        bus.outbound_ready = 1'b0;
        send(64'd9876, a);
        bus.result_valid = 1'b0;
        wait_valid(8'h39);
        bus.outbound_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.outbound_ready = 1'b0;
        wait_valid(8'h38);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_q.delete();
        lat_q.delete();
        first      = 1'b1;
        prev_stall = 1'b0;
        @(negedge clk);
        chk("abort_outbound_valid", bus.outbound_valid, 0);
        chk("abort_result_ready", bus.result_ready, 1);
        chk("abort_busy", bus.busy, 0);
        @(posedge clk);
        #1;
        mode = 0;
        one(64'd5);

        for (int i = 0; i < 8; i++) begin
            mode = i % 2;
            v = {$urandom, $urandom} >> $urandom_range(0, 63);
            one(v);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
